timing_controller: RTL and testbench
====================================

TIMING_CONTROLLER -- requirements
Module: timing_controller

Interface
REQ-001 Parameter: COUNT_WIDTH, default 8, width of instr_count.
REQ-002 Clock: clk, input, 1; all state changes on rising edge.
REQ-003 Reset: reset, input, 1; asynchronous, active-high.
REQ-004 run, input, 1: level request for free-running execution; synchronous to clk.
REQ-005 step, input, 1: single-instruction request; synchronous to clk; only its rising edge is acted upon.
REQ-006 halt_req, input, 1: HLT decoded by instruction decoder; valid during any T-state.
REQ-007 pc_last, input, 1: program counter currently at 5'b11111.
REQ-008 Timing_Signal, output, 2: T-state code to program counter and datapath (00=T0, 01=T1, 10=T2, 11=T3).
REQ-009 t_onehot, output, 4: one-hot T-state (bit n = Tn), 4'b0000 when cycle_active=0.
REQ-010 cycle_active, output, 1: current Timing_Signal is a live T-state.
REQ-011 running, output, 1: controller in RUN state.
REQ-012 halted, output, 1: controller in HALTED state.
REQ-013 instr_count, output, COUNT_WIDTH: completed instruction cycles.

Function
REQ-014 States SHALL be IDLE, RUN, STEP, HALTED; all outputs SHALL be registered.
REQ-015 In IDLE and HALTED, Timing_Signal SHALL be 2'b00, cycle_active 0, t_onehot 4'b0000, so the program counter never sees T3.
REQ-016 IDLE: run=1 sampled -> RUN at that edge with Timing_Signal=00, cycle_active=1; else step rising edge -> STEP identically; run has priority and a coincident step edge is discarded.
REQ-017 Step edge detection SHALL use a registered copy of step; step edges in RUN, STEP, or HALTED are ignored and not queued.
REQ-018 In RUN/STEP, Timing_Signal SHALL advance 00->01->10->11 one state per clock, no stalls.
REQ-019 halt_req SHALL be latched into a sticky flag on any active T-state edge, including at T3; the flag clears when a new T0 is entered.
REQ-020 At the T3 edge, the next state SHALL be chosen in priority order: halt flag or halt_req=1 -> HALTED; pc_last=1 -> HALTED; STEP -> IDLE; RUN with run=0 -> IDLE; otherwise stay in RUN at T0.
REQ-021 Deasserting run mid-cycle SHALL NOT truncate the cycle; the current T0..T3 SHALL complete.
REQ-022 instr_count SHALL increment by 1 at every active T3 edge, including the one entering HALTED, and saturate at all-ones.
REQ-023 HALTED SHALL be exited only by reset; run and step are ignored there.
REQ-024 running=1 only in RUN; halted=1 only in HALTED; both SHALL never be 1 together.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE with Timing_Signal=00, t_onehot=0000, cycle_active=0, running=0, halted=0, instr_count=0, halt flag=0, and step history=0, including mid-cycle (for example at T2).
REQ-026 After reset release, a step held high from before release SHALL NOT count as a rising edge.

Verification
REQ-027 Free run: run=1 for 12 clocks from IDLE -> Timing_Signal 00,01,10,11 repeating, t_onehot 0001,0010,0100,1000, instr_count=3.
REQ-028 Single step: one-clock step pulse in IDLE -> exactly one T0..T3 sequence, then IDLE, instr_count=1; a second pulse given during T1 is ignored.
REQ-029 HLT: run=1, halt_req pulsed during T1 of the 2nd cycle -> cycle completes T3, halted=1, Timing_Signal=00, instr_count=2, and a later run or step has no effect.
REQ-030 End of program: pc_last=1 at T3 -> HALTED after that edge, instr_count incremented once.
REQ-031 Run drop: run deasserted at T1 -> T2 and T3 still issued, then IDLE with running=0.
REQ-032 Reset mid-cycle: reset at T2 with instr_count=5 -> all outputs 0 immediately; run and step coincident after release -> RUN, instr_count saturating test with COUNT_WIDTH=2 reaches 3 and holds.

Source files
------------

// File: rtl/timing_controller.sv
// Instruction-cycle timing controller: sequences T0..T3 for the program counter
// and datapath, in free-run or single-step mode, until a halt or program end.
module timing_controller #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic                   halt_req,
  input  logic                   pc_last,
  output logic [1:0]             Timing_Signal,
  output logic [3:0]             t_onehot,
  output logic                   cycle_active,
  output logic                   running,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTED
  } state_e;

  localparam logic [1:0] T3 = 2'b11;

  state_e                 state_q, state_d;
  logic [1:0]             t_q, t_d;
  logic                   halt_flag_q, halt_flag_d;
  logic                   step_prev_q, step_prev_d;
  logic                   armed_q, armed_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   cycle_active_q, cycle_active_d;
  logic                   running_q, running_d;
  logic                   halted_q, halted_d;
  logic [3:0]             t_onehot_q, t_onehot_d;

  logic step_rise;
  logic halt_seen;

  // The first edge after reset only primes the step history, so a step held
  // across reset release never looks like a fresh rising edge.
  assign step_rise = step & ~step_prev_q & armed_q;
  assign halt_seen = halt_flag_q | halt_req;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    t_d         = t_q;
    halt_flag_d = halt_flag_q;
    step_prev_d = step;
    armed_d     = 1'b1;
    count_d     = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d     = ST_RUN;
          t_d         = 2'b00;
          halt_flag_d = 1'b0;
        end else if (step_rise) begin
          state_d     = ST_STEP;
          t_d         = 2'b00;
          halt_flag_d = 1'b0;
        end
      end

      ST_RUN, ST_STEP: begin
        halt_flag_d = halt_seen;
        if (t_q != T3) begin
          t_d = t_q + 2'd1;
        end else begin
          // End of an instruction cycle: count it, then pick the successor.
          count_d = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
          t_d     = 2'b00;
          if (halt_seen || pc_last) begin
            state_d = ST_HALTED;
          end else if (state_q == ST_STEP || !run) begin
            state_d = ST_IDLE;
          end else begin
            halt_flag_d = 1'b0;
          end
        end
      end

      ST_HALTED: begin
        // Only reset leaves this state.
      end
    endcase

    cycle_active_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    running_d      = (state_d == ST_RUN);
    halted_d       = (state_d == ST_HALTED);
    t_onehot_d     = cycle_active_d ? (4'b0001 << t_d) : 4'b0000;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      t_q            <= 2'b00;
      halt_flag_q    <= 1'b0;
      step_prev_q    <= 1'b0;
      armed_q        <= 1'b0;
      count_q        <= '0;
      cycle_active_q <= 1'b0;
      running_q      <= 1'b0;
      halted_q       <= 1'b0;
      t_onehot_q     <= 4'b0000;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      halt_flag_q    <= halt_flag_d;
      step_prev_q    <= step_prev_d;
      armed_q        <= armed_d;
      count_q        <= count_d;
      cycle_active_q <= cycle_active_d;
      running_q      <= running_d;
      halted_q       <= halted_d;
      t_onehot_q     <= t_onehot_d;
    end
  end

  // t_q is forced to T0 whenever no cycle is live, so the PC never sees T3.
  assign Timing_Signal = t_q;
  assign t_onehot      = t_onehot_q;
  assign cycle_active  = cycle_active_q;
  assign running       = running_q;
  assign halted        = halted_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_timing_controller.sv
// Directed bench for timing_controller: free run, single step, halt, program
// end, run drop, mid-cycle reset and counter saturation on a 2-bit instance.
module tb_timing_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       run, step, halt_req, pc_last;
  logic [1:0] ts, ts_s;
  logic [3:0] oh, oh_s;
  logic       act, act_s, rn, rn_s, hl, hl_s;
  logic [7:0] cnt;
  logic [1:0] cnt_s;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  timing_controller dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .pc_last(pc_last), .Timing_Signal(ts), .t_onehot(oh), .cycle_active(act),
    .running(rn), .halted(hl), .instr_count(cnt)
  );

  timing_controller #(.COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .pc_last(pc_last), .Timing_Signal(ts_s), .t_onehot(oh_s), .cycle_active(act_s),
    .running(rn_s), .halted(hl_s), .instr_count(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every output of the default-width instance against one expected state.
  task automatic check_all(input string tag, input int e_ts, input bit e_act,
                           input bit e_run, input bit e_hlt, input int e_cnt);
    logic [3:0] e_oh;
    e_oh = e_act ? (4'b0001 << e_ts) : 4'b0000;
    check({tag, ".ts"},      32'(ts),  32'(e_ts));
    check({tag, ".onehot"},  32'(oh),  32'(e_oh));
    check({tag, ".active"},  32'(act), 32'(e_act));
    check({tag, ".running"}, 32'(rn),  32'(e_run));
    check({tag, ".halted"},  32'(hl),  32'(e_hlt));
    check({tag, ".count"},   32'(cnt), 32'(e_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; pc_last = 1'b0;
    #12;
    check_all("reset", 0, 0, 0, 0, 0);
    check("reset.sat_count", 32'(cnt_s), 0);
    @(posedge clk); #1 reset = 1'b0;
    tick();
    check_all("idle", 0, 0, 0, 0, 0);

    // Free run for 12 clocks, then drop run and let the third cycle finish.
    run = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_all($sformatf("run_k%0d", k), k % 4, 1, 1, 0, k / 4);
    end
    run = 1'b0;
    tick();
    check_all("run_end", 0, 0, 0, 0, 3);

    // Single step, with a second step pulse during T1 that must be ignored.
    step = 1'b1; tick(); step = 1'b0;
    check_all("step_t0", 0, 1, 0, 0, 3);
    tick();
    check_all("step_t1", 1, 1, 0, 0, 3);
    step = 1'b1; tick(); step = 1'b0;
    check_all("step_t2", 2, 1, 0, 0, 3);
    tick();
    check_all("step_t3", 3, 1, 0, 0, 3);
    tick();
    check_all("step_done", 0, 0, 0, 0, 4);
    tick();
    check_all("step_no_queue", 0, 0, 0, 0, 4);

    // Run dropped at T1: T2 and T3 still issue, then IDLE.
    run = 1'b1; tick();
    check_all("drop_t0", 0, 1, 1, 0, 4);
    tick();
    check_all("drop_t1", 1, 1, 1, 0, 4);
    run = 1'b0; tick();
    check_all("drop_t2", 2, 1, 1, 0, 4);
    tick();
    check_all("drop_t3", 3, 1, 1, 0, 4);
    tick();
    check_all("drop_idle", 0, 0, 0, 0, 5);

    // Reset at T2 with five completed instructions.
    run = 1'b1; tick(); tick(); tick();
    check_all("pre_reset_t2", 2, 1, 1, 0, 5);
    check("pre_reset.sat_count", 32'(cnt_s), 3);
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0);
    check("async_reset.sat_count", 32'(cnt_s), 0);

    // run and step together after release: run wins; then saturate 2-bit count.
    run = 1'b1; step = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    tick();
    check_all("rs_t0", 0, 1, 1, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_all($sformatf("sat_k%0d", k), k % 4, 1, 1, 0, k / 4);
      check($sformatf("sat_k%0d.sat_count", k), 32'(cnt_s), (k / 4 > 3) ? 3 : k / 4);
    end
    run = 1'b0; step = 1'b0;
    tick(); tick(); tick(); tick();
    check_all("sat_idle", 0, 0, 0, 0, 5);
    check("sat_idle.sat_count", 32'(cnt_s), 3);

    // HLT pulsed during T1 of the second cycle.
    reset = 1'b1; tick(); reset = 1'b0;
    run = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check_all("hlt_c2_t0", 0, 1, 1, 0, 1);
    tick();
    check_all("hlt_c2_t1", 1, 1, 1, 0, 1);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    check_all("hlt_c2_t2", 2, 1, 1, 0, 1);
    tick();
    check_all("hlt_c2_t3", 3, 1, 1, 0, 1);
    tick();
    check_all("hlt_halted", 0, 0, 0, 1, 2);
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    check_all("hlt_sticky", 0, 0, 0, 1, 2);

    // Step held across reset release is not an edge; then pc_last at T3.
    reset = 1'b1; run = 1'b0; step = 1'b1; tick(); reset = 1'b0;
    tick(); tick();
    check_all("held_step", 0, 0, 0, 0, 0);
    step = 1'b0; tick();
    step = 1'b1; tick(); step = 1'b0;
    check_all("pc_t0", 0, 1, 0, 0, 0);
    tick(); tick(); tick();
    check_all("pc_t3", 3, 1, 0, 0, 0);
    pc_last = 1'b1; tick(); pc_last = 1'b0;
    check_all("pc_halted", 0, 0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
